// File: rtl/adder_pipe_if.sv
// Handshake and operand/result bundle for adder_pipe; master drives operands, slave is the adder.
// The ovf signal exists only when ADDER_PIPE_OVF_EN is defined.
interface adder_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef ADDER_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef ADDER_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef ADDER_PIPE_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_pipe_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic adv;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage k sees only the not-yet-resolved upper operand bits (shifted down) and
  // appends its slice on top of the already-resolved lower result bits.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int unsigned SW = WIDTH - k * CHUNK;
    localparam int unsigned RW = (k + 1) * CHUNK;

    logic [SW-1:0]    src_a;
    logic [SW-1:0]    src_b;
    logic             src_c;
    logic             src_v;
    logic [CHUNK-1:0] s;
    logic             c;
    logic             v_q;
    logic             c_q;
    logic [RW-1:0]    r_q;

    if (k == 0) begin : g_in
      assign src_a = bus.a;
      assign src_b = bus.sub ? ~bus.b : bus.b;
      assign src_c = bus.sub | bus.c_in;
      assign src_v = bus.in_valid;
    end else begin : g_in
      assign src_a = stg[k-1].g_skew.a_q;
      assign src_b = stg[k-1].g_skew.b_q;
      assign src_c = stg[k-1].c_q;
      assign src_v = stg[k-1].v_q;
    end

    assign {c, s} = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, src_c};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= src_v;
        c_q <= c;
      end
    end

    if (k == 0) begin : g_res
      always_ff @(posedge clk) begin
        if (!rst_n)   r_q <= '0;
        else if (adv) r_q <= s;
      end
    end else begin : g_res
      always_ff @(posedge clk) begin
        if (!rst_n)   r_q <= '0;
        else if (adv) r_q <= {s, stg[k-1].r_q};
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [SW-CHUNK-1:0] a_q;
      logic [SW-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q <= src_a[SW-1:CHUNK];
          b_q <= src_b[SW-1:CHUNK];
        end
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic msb_cin;
      logic ovf_q;

      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign msb_cin = src_a[CHUNK-1] ^ src_b[CHUNK-1] ^ s[CHUNK-1];

      always_ff @(posedge clk) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= msb_cin ^ c;
      end
    end
`endif
  end

  assign bus.out_valid = stg[STAGES-1].v_q;
  assign bus.sum       = stg[STAGES-1].r_q;
  assign bus.c_out     = stg[STAGES-1].c_q;
`ifdef ADDER_PIPE_OVF_EN
  assign bus.ovf       = stg[STAGES-1].g_ovf.ovf_q;
`endif
endmodule
